// File: rtl/sensor_offset_calibrator.sv
// Sensor offset calibrator.
// Runs the sensor, averages 2^LOG2_DEPTH sample sets per channel, latches the
// floored per-channel averages as offsets and flags channels whose offset
// magnitude exceeds LIMIT. A tick-based timeout bounds the collection window.
module sensor_offset_calibrator #(
  parameter int NCH           = 6,
  parameter int W             = 16,
  parameter int LOG2_DEPTH    = 6,
  parameter int TIMEOUT_TICKS = 3,
  parameter int LIMIT         = 4500
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               tick,
  input  logic               sample_valid,
  input  logic [NCH*W-1:0]   sample_data,
  output logic               sensor_start,
  output logic               sensor_reset,
  output logic               busy,
  output logic               done,
  output logic               error_timeout,
  output logic               error_range,
  output logic [NCH-1:0]     range_mask,
  output logic [NCH*W-1:0]   offsets
);

  // Accumulator width: a sum of 2^LOG2_DEPTH W-bit signed values always fits.
  localparam int AW    = W + LOG2_DEPTH;
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int CW    = LOG2_DEPTH + 1;
  localparam int TW    = $clog2(TIMEOUT_TICKS + 1);

  // Limits widened by two bits so that -LIMIT and +LIMIT are both representable
  // and the comparison against a sign-extended offset is exact.
  localparam logic signed [W+1:0] LIM_POS = (W+2)'(LIMIT);
  localparam logic signed [W+1:0] LIM_NEG = -LIM_POS;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] ARM         = 3'd1;
  localparam logic [2:0] FILL        = 3'd2;
  localparam logic [2:0] CHECK       = 3'd3;
  localparam logic [2:0] DONE        = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;
  localparam logic [2:0] ERR_RANGE   = 3'd6;

  logic [2:0]    state_reg, state_next;
  logic          sensor_start_reg, sensor_start_next;
  logic          sensor_reset_reg, sensor_reset_next;
  logic [CW-1:0] sample_cnt_reg, sample_cnt_next;
  logic [TW-1:0] tick_cnt_reg, tick_cnt_next;

  // Per-cycle strobes shared by every channel datapath.
  logic          start_accept;
  logic          acc_en;
  logic          latch_en;
  logic          last_sample;
  logic          timeout_hit;
  logic [NCH-1:0] mask_calc;

  // The final sample and the timeout-completing tick are detected
  // independently so that completion can win when both arrive together.
  assign last_sample = sample_valid && (sample_cnt_reg == CW'(DEPTH - 1));
  assign timeout_hit = tick && (tick_cnt_reg == TW'(TIMEOUT_TICKS - 1));

  // Next-state and control decode; abort overrides everything while busy.
  always_comb begin
    state_next        = state_reg;
    sensor_start_next = sensor_start_reg;
    sensor_reset_next = sensor_reset_reg;
    sample_cnt_next   = sample_cnt_reg;
    tick_cnt_next     = tick_cnt_reg;
    start_accept      = 1'b0;
    acc_en            = 1'b0;
    latch_en          = 1'b0;

    case (state_reg)
      IDLE, DONE, ERR_TIMEOUT, ERR_RANGE: begin
        if (start) begin
          state_next      = ARM;
          start_accept    = 1'b1;
          sample_cnt_next = '0;
          tick_cnt_next   = '0;
        end
      end

      ARM: begin
        if (abort) begin
          state_next        = IDLE;
          sensor_start_next = 1'b0;
          sensor_reset_next = 1'b1;
        end else begin
          state_next        = FILL;
          sensor_reset_next = 1'b0;
          sensor_start_next = 1'b1;
        end
      end

      FILL: begin
        if (abort) begin
          state_next        = IDLE;
          sensor_start_next = 1'b0;
          sensor_reset_next = 1'b1;
        end else begin
          if (sample_valid) begin
            acc_en          = 1'b1;
            sample_cnt_next = sample_cnt_reg + CW'(1);
          end
          if (tick) begin
            tick_cnt_next = tick_cnt_reg + TW'(1);
          end
          if (last_sample) begin
            state_next        = CHECK;
            sensor_start_next = 1'b0;
          end else if (timeout_hit) begin
            state_next        = ERR_TIMEOUT;
            sensor_start_next = 1'b0;
          end
        end
      end

      CHECK: begin
        if (abort) begin
          state_next        = IDLE;
          sensor_start_next = 1'b0;
          sensor_reset_next = 1'b1;
        end else begin
          latch_en   = 1'b1;
          state_next = (|mask_calc) ? ERR_RANGE : DONE;
        end
      end

      default: begin
        state_next        = IDLE;
        sensor_start_next = 1'b0;
        sensor_reset_next = 1'b1;
      end
    endcase
  end

  // Control state registers; reset parks the sensor in reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      sensor_start_reg <= 1'b0;
      sensor_reset_reg <= 1'b1;
      sample_cnt_reg   <= '0;
      tick_cnt_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      sensor_start_reg <= sensor_start_next;
      sensor_reset_reg <= sensor_reset_next;
      sample_cnt_reg   <= sample_cnt_next;
      tick_cnt_reg     <= tick_cnt_next;
    end
  end

  assign sensor_start  = sensor_start_reg;
  assign sensor_reset  = sensor_reset_reg;
  assign busy          = (state_reg == ARM) || (state_reg == FILL) || (state_reg == CHECK);
  assign done          = (state_reg == DONE);
  assign error_timeout = (state_reg == ERR_TIMEOUT);
  assign error_range   = (state_reg == ERR_RANGE);

  // One accumulate / average / range-check datapath per channel.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic signed [W-1:0]  sample_s;
    logic signed [AW-1:0] acc_reg;
    logic signed [W-1:0]  offset_reg;
    logic signed [W-1:0]  offset_calc;
    logic signed [W+1:0]  offset_ext;
    logic                 mask_reg;

    assign sample_s = sample_data[gi*W +: W];

    // Dropping the low LOG2_DEPTH bits of a two's-complement sum is an
    // arithmetic shift, i.e. a floor toward minus infinity.
    assign offset_calc   = acc_reg[AW-1:LOG2_DEPTH];
    assign offset_ext    = {{2{offset_calc[W-1]}}, offset_calc};
    assign mask_calc[gi] = (offset_ext > LIM_POS) || (offset_ext < LIM_NEG);

    // Signed running sum of this channel's samples for the current run.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        acc_reg <= '0;
      end else if (start_accept) begin
        acc_reg <= '0;
      end else if (acc_en) begin
        acc_reg <= acc_reg + {{LOG2_DEPTH{sample_s[W-1]}}, sample_s};
      end
    end

    // Averaged offset, kept across aborts, timeouts and new starts.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        offset_reg <= '0;
      end else if (latch_en) begin
        offset_reg <= offset_calc;
      end
    end

    // Out-of-range flag, cleared when a new run starts.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        mask_reg <= 1'b0;
      end else if (start_accept) begin
        mask_reg <= 1'b0;
      end else if (latch_en) begin
        mask_reg <= mask_calc[gi];
      end
    end

    assign offsets[gi*W +: W] = offset_reg;
    assign range_mask[gi]     = mask_reg;
  end

endmodule
